// File: rtl/k12a_fetch_sequencer_pkg.sv
// Shared types and defaults for the k12a fetch sequencer.
// Latency: n/a (types only). Backpressure: n/a.
// Contents: fetch FSM state encoding, reset PC default, wait counter width.
package k12a_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        FS_IDLE   = 3'd0,
        FS_REQ_HI = 3'd1,
        FS_REQ_LO = 3'd2,
        FS_EXEC   = 3'd3,
        FS_FAULT  = 3'd4
    } k12a_fetch_state_t;

    localparam logic [15:0] K12A_RESET_PC = 16'h0000;
    localparam int          K12A_WAIT_W   = 8;

endpackage

// File: rtl/k12a_wait_timer.sv
// Saturating wait counter; expired flags the last allowed unacked request cycle.
// Latency: count updates at the next edge; expired is decoded from the registered count.
// Backpressure: none; clear has priority over inc.
module k12a_wait_timer
    import k12a_fetch_sequencer_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int WIDTH    = K12A_WAIT_W
) (
    input  logic cpu_clock,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX_WAIT - 1);

    logic [WIDTH-1:0] count;

    always_ff @(posedge cpu_clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/k12a_fetch_sequencer.sv
// Fetches two instruction bytes (high then low) at pc, holds them for execute, applies jumps.
// Latency: 2 cycles minimum from first request to inst_valid; store pulses are combinational with mem_ack.
// Backpressure: mem_req held until mem_ack (bus fault after MAX_WAIT unacked cycles); EXEC holds until exec_done.
module k12a_fetch_sequencer
    import k12a_fetch_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_PC = K12A_RESET_PC,
    parameter int          MAX_WAIT = 15
) (
    input  logic        cpu_clock,
    input  logic        reset,
    input  logic        run,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    output logic        inst_high_store,
    output logic        inst_low_store,
    output logic        inst_valid,
    input  logic        exec_done,
    input  logic        jump_en,
    input  logic [15:0] jump_target,
    output logic [15:0] pc,
    output logic        bus_fault
);

    k12a_fetch_state_t state;
    logic              in_req;
    logic              wait_expired;

    assign in_req = (state == FS_REQ_HI) || (state == FS_REQ_LO);

    // The counter sits at zero outside the request states, so every REQ_* entry starts fresh.
    k12a_wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .WIDTH    (K12A_WAIT_W)
    ) u_wait_timer (
        .cpu_clock (cpu_clock),
        .reset     (reset),
        .clear     (!in_req || mem_ack),
        .inc       (in_req && !mem_ack),
        .expired   (wait_expired)
    );

    always_ff @(posedge cpu_clock) begin
        if (reset) begin
            state <= FS_IDLE;
            pc    <= RESET_PC;
        end else begin
            case (state)
                FS_IDLE: begin
                    if (run) state <= FS_REQ_HI;
                end
                FS_REQ_HI: begin
                    if (mem_ack) begin
                        pc    <= pc + 16'd1;
                        state <= FS_REQ_LO;
                    end else if (wait_expired) begin
                        state <= FS_FAULT;
                    end
                end
                FS_REQ_LO: begin
                    if (mem_ack) begin
                        pc    <= pc + 16'd1;
                        state <= FS_EXEC;
                    end else if (wait_expired) begin
                        state <= FS_FAULT;
                    end
                end
                FS_EXEC: begin
                    if (exec_done) begin
                        if (jump_en) pc <= jump_target;
                        state <= run ? FS_REQ_HI : FS_IDLE;
                    end
                end
                FS_FAULT: state <= FS_FAULT;
                default:  state <= FS_IDLE;
            endcase
        end
    end

    // Reset suppresses the bus request and any capture strobe in the same cycle.
    assign mem_req         = in_req && !reset;
    assign mem_addr        = mem_req ? pc : 16'h0000;
    assign inst_high_store = (state == FS_REQ_HI) && mem_ack && !reset;
    assign inst_low_store  = (state == FS_REQ_LO) && mem_ack && !reset;
    assign inst_valid      = (state == FS_EXEC);
    assign bus_fault       = (state == FS_FAULT);

endmodule

// File: tb/tb_k12a_fetch_sequencer.sv
// Cycle-level vector bench for k12a_fetch_sequencer: inputs driven after posedge, outputs checked at negedge.
module tb_k12a_fetch_sequencer;

    logic        cpu_clock;
    logic        reset;
    logic        run;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic        inst_high_store;
    logic        inst_low_store;
    logic        inst_valid;
    logic        exec_done;
    logic        jump_en;
    logic [15:0] jump_target;
    logic [15:0] pc;
    logic        bus_fault;

    k12a_fetch_sequencer #(
        .RESET_PC (16'h0000),
        .MAX_WAIT (15)
    ) dut (
        .cpu_clock       (cpu_clock),
        .reset           (reset),
        .run             (run),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_ack         (mem_ack),
        .inst_high_store (inst_high_store),
        .inst_low_store  (inst_low_store),
        .inst_valid      (inst_valid),
        .exec_done       (exec_done),
        .jump_en         (jump_en),
        .jump_target     (jump_target),
        .pc              (pc),
        .bus_fault       (bus_fault)
    );

    initial cpu_clock = 1'b0;
    always #5 cpu_clock = ~cpu_clock;

    typedef struct {
        logic        rst;
        logic        run;
        logic        ack;
        logic        done;
        logic        jen;
        logic [15:0] jt;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_hi;
        logic        e_lo;
        logic        e_valid;
        logic [15:0] e_pc;
        logic        e_fault;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[27];
    int   n_pass  = 0;
    int   n_total = 0;
    int   vec_no  = 0;

    function automatic vec_t mk(logic rst, logic rn, logic ack, logic done, logic jen, logic [15:0] jt,
                                logic req, logic [15:0] addr, logic hi, logic lo, logic vld,
                                logic [15:0] p, logic flt);
        vec_t v;
        v.rst = rst; v.run = rn; v.ack = ack; v.done = done; v.jen = jen; v.jt = jt;
        v.e_req = req; v.e_addr = addr; v.e_hi = hi; v.e_lo = lo; v.e_valid = vld;
        v.e_pc = p; v.e_fault = flt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s vec %0d: got %h want %h", name, vec_no, got, want);
    endtask

    task automatic step(input vec_t v);
        vec_t e;
        @(posedge cpu_clock);
        #1;
        reset       = v.rst;
        run         = v.run;
        mem_ack     = v.ack;
        exec_done   = v.done;
        jump_en     = v.jen;
        jump_target = v.jt;
        exp_q.push_back(v);
        @(negedge cpu_clock);
        e = exp_q.pop_front();
        chk("mem_req",         {15'd0, mem_req},         {15'd0, e.e_req});
        chk("mem_addr",        mem_addr,                 e.e_addr);
        chk("inst_high_store", {15'd0, inst_high_store}, {15'd0, e.e_hi});
        chk("inst_low_store",  {15'd0, inst_low_store},  {15'd0, e.e_lo});
        chk("inst_valid",      {15'd0, inst_valid},      {15'd0, e.e_valid});
        chk("pc",              pc,                       e.e_pc);
        chk("bus_fault",       {15'd0, bus_fault},       {15'd0, e.e_fault});
        vec_no++;
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
        jump_en = 1'b0; jump_target = 16'h0000;

        // Back-to-back fetch, ignored/accepted jump, run drop mid-fetch, delayed high-byte ack.
        tbl[0]  = mk(0,0,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0000,0);
        tbl[1]  = mk(0,1,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0000,0);
        tbl[2]  = mk(0,1,1,0,0,16'h0000, 1,16'h0000,1,0,0,16'h0000,0);
        tbl[3]  = mk(0,1,1,0,0,16'h0000, 1,16'h0001,0,1,0,16'h0001,0);
        tbl[4]  = mk(0,1,0,0,0,16'h0000, 0,16'h0000,0,0,1,16'h0002,0);
        tbl[5]  = mk(0,1,0,1,0,16'h0000, 0,16'h0000,0,0,1,16'h0002,0);
        tbl[6]  = mk(0,1,1,0,0,16'h0000, 1,16'h0002,1,0,0,16'h0002,0);
        tbl[7]  = mk(0,1,1,0,0,16'h0000, 1,16'h0003,0,1,0,16'h0003,0);
        tbl[8]  = mk(0,1,0,0,1,16'h1234, 0,16'h0000,0,0,1,16'h0004,0);
        tbl[9]  = mk(0,1,0,0,0,16'h0000, 0,16'h0000,0,0,1,16'h0004,0);
        tbl[10] = mk(0,1,0,1,1,16'h1234, 0,16'h0000,0,0,1,16'h0004,0);
        tbl[11] = mk(0,1,0,0,0,16'h0000, 1,16'h1234,0,0,0,16'h1234,0);
        tbl[12] = mk(0,1,1,0,0,16'h0000, 1,16'h1234,1,0,0,16'h1234,0);
        tbl[13] = mk(0,0,1,0,0,16'h0000, 1,16'h1235,0,1,0,16'h1235,0);
        tbl[14] = mk(0,0,0,1,0,16'h0000, 0,16'h0000,0,0,1,16'h1236,0);
        tbl[15] = mk(0,0,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h1236,0);
        tbl[16] = mk(0,0,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h1236,0);
        tbl[17] = mk(0,1,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h1236,0);
        tbl[18] = mk(0,1,0,0,0,16'h0000, 1,16'h1236,0,0,0,16'h1236,0);
        tbl[19] = mk(0,1,0,0,0,16'h0000, 1,16'h1236,0,0,0,16'h1236,0);
        tbl[20] = mk(0,1,0,0,0,16'h0000, 1,16'h1236,0,0,0,16'h1236,0);
        tbl[21] = mk(0,1,1,0,0,16'h0000, 1,16'h1236,1,0,0,16'h1236,0);
        tbl[22] = mk(0,0,0,0,0,16'h0000, 1,16'h1237,0,0,0,16'h1237,0);
        tbl[23] = mk(0,0,1,0,0,16'h0000, 1,16'h1237,0,1,0,16'h1237,0);
        tbl[24] = mk(0,0,1,0,0,16'h0000, 0,16'h0000,0,0,1,16'h1238,0);
        tbl[25] = mk(0,0,0,1,0,16'h0000, 0,16'h0000,0,0,1,16'h1238,0);
        tbl[26] = mk(0,0,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h1238,0);

        repeat (2) @(posedge cpu_clock);
        for (int i = 0; i < 27; i++) step(tbl[i]);

        // PC wrap: jump to FFFF, fetch FFFF then 0000.
        step(mk(0,1,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h1238,0));
        step(mk(0,1,1,0,0,16'h0000, 1,16'h1238,1,0,0,16'h1238,0));
        step(mk(0,1,1,0,0,16'h0000, 1,16'h1239,0,1,0,16'h1239,0));
        step(mk(0,1,0,1,1,16'hFFFF, 0,16'h0000,0,0,1,16'h123A,0));
        step(mk(0,1,1,0,0,16'h0000, 1,16'hFFFF,1,0,0,16'hFFFF,0));
        step(mk(0,1,1,0,0,16'h0000, 1,16'h0000,0,1,0,16'h0000,0));
        step(mk(0,0,0,1,0,16'h0000, 0,16'h0000,0,0,1,16'h0001,0));
        step(mk(0,0,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0001,0));

        // Reset in REQ_LO with ack pending: no low store, back to IDLE at RESET_PC.
        step(mk(0,1,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0001,0));
        step(mk(0,1,1,0,0,16'h0000, 1,16'h0001,1,0,0,16'h0001,0));
        step(mk(1,1,1,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0002,0));
        step(mk(0,0,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0000,0));

        // Timeout: 15 unacked cycles then sticky fault; late ack ignored; only reset clears.
        step(mk(0,1,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0000,0));
        for (int i = 0; i < 15; i++)
            step(mk(0,1,0,0,0,16'h0000, 1,16'h0000,0,0,0,16'h0000,0));
        step(mk(0,1,1,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0000,1));
        step(mk(0,1,1,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0000,1));
        step(mk(1,0,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0000,1));
        step(mk(0,0,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0000,0));

        // Ack on the 15th cycle of each byte: no fault, counter restarts for the low byte.
        step(mk(0,1,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0000,0));
        for (int i = 0; i < 14; i++)
            step(mk(0,1,0,0,0,16'h0000, 1,16'h0000,0,0,0,16'h0000,0));
        step(mk(0,1,1,0,0,16'h0000, 1,16'h0000,1,0,0,16'h0000,0));
        for (int i = 0; i < 14; i++)
            step(mk(0,0,0,0,0,16'h0000, 1,16'h0001,0,0,0,16'h0001,0));
        step(mk(0,0,1,0,0,16'h0000, 1,16'h0001,0,1,0,16'h0001,0));
        step(mk(0,0,0,1,0,16'h0000, 0,16'h0000,0,0,1,16'h0002,0));
        step(mk(0,0,0,0,0,16'h0000, 0,16'h0000,0,0,0,16'h0002,0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
